// File: rtl/eeprom_rw_ctrl_if.sv
// Link between the EEPROM transaction sequencer and the byte-level I2C master.
interface eeprom_rw_ctrl_if;
  // m_req is a one-cycle command strobe qualifying m_cmd/m_din; there is no back-pressure.
  // m_done is a one-cycle completion strobe per byte, qualifying m_dout.
  logic       m_req;
  logic [3:0] m_cmd;
  logic [7:0] m_din;
  logic [7:0] m_dout;
  logic       m_done;

  modport master (output m_req, m_cmd, m_din, input m_dout, m_done);
  modport slave  (input m_req, m_cmd, m_din, output m_dout, m_done);
endinterface

// File: rtl/eeprom_rw_ctrl.sv
// Sequences single-byte EEPROM writes/reads into I2C master byte commands.
// Optional post-write settle wait is enabled by defining EEPROM_WR_WAIT_EN.
module eeprom_rw_ctrl #(
  parameter logic [6:0]  DEV_ADDR = 7'b1010_000,
  parameter int unsigned WR_WAIT  = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic [7:0] rdata,
  output logic       rdata_vld,
  output logic       wr_done,
  eeprom_rw_ctrl_if.master i2c,
  output logic [9:0] state_dbg
);

  typedef enum logic [9:0] {
    IDLE   = 10'b00_0000_0001,
    W_DEV  = 10'b00_0000_0010,
    W_ADDR = 10'b00_0000_0100,
    W_DATA = 10'b00_0000_1000,
    R_DEV  = 10'b00_0001_0000,
    R_ADDR = 10'b00_0010_0000,
    R_RDEV = 10'b00_0100_0000,
    R_DATA = 10'b00_1000_0000,
    W_WAIT = 10'b01_0000_0000,
    FIN    = 10'b10_0000_0000
  } state_t;

  state_t     state, state_next, state_prev;
  logic [7:0] addr_q, wdata_q;
  logic       is_wr;
  logic       byte_state;
  logic       issue;
  logic [3:0] cmd_sel;
  logic [7:0] din_sel;

`ifdef EEPROM_WR_WAIT_EN
  localparam int CW = $clog2(WR_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  logic          wait_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != W_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign wait_last = (wait_cnt == CW'(WR_WAIT - 1));
`else
  logic unused_wr_wait;
  assign unused_wr_wait = (WR_WAIT != 0);
`endif

  // Command/data for the byte belonging to the current state.
  always_comb begin
    byte_state = 1'b1;
    cmd_sel    = 4'b0000;
    din_sel    = 8'h00;
    case (state)
      W_DEV, R_DEV: begin
        cmd_sel = 4'b0011;
        din_sel = {DEV_ADDR, 1'b0};
      end
      W_ADDR, R_ADDR: begin
        cmd_sel = 4'b0010;
        din_sel = addr_q;
      end
      W_DATA: begin
        cmd_sel = 4'b1010;
        din_sel = wdata_q;
      end
      R_RDEV: begin
        cmd_sel = 4'b0011;
        din_sel = {DEV_ADDR, 1'b1};
      end
      R_DATA: begin
        cmd_sel = 4'b1100;
        din_sel = 8'h00;
      end
      default: byte_state = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_req)      state_next = W_DEV;
        else if (rd_req) state_next = R_DEV;
      end
      W_DEV:  if (i2c.m_done) state_next = W_ADDR;
      W_ADDR: if (i2c.m_done) state_next = W_DATA;
`ifdef EEPROM_WR_WAIT_EN
      W_DATA: if (i2c.m_done) state_next = W_WAIT;
      W_WAIT: if (wait_last)  state_next = FIN;
`else
      W_DATA: if (i2c.m_done) state_next = FIN;
`endif
      R_DEV:  if (i2c.m_done) state_next = R_ADDR;
      R_ADDR: if (i2c.m_done) state_next = R_RDEV;
      R_RDEV: if (i2c.m_done) state_next = R_DATA;
      R_DATA: if (i2c.m_done) state_next = FIN;
      FIN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      state_prev <= IDLE;
    end else begin
      state      <= state_next;
      state_prev <= state;
    end
  end

  // A byte is issued once, in the cycle after its state is entered.
  assign issue = byte_state && (state != state_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      is_wr      <= 1'b0;
      rdata      <= 8'h00;
      rdata_vld  <= 1'b0;
      wr_done    <= 1'b0;
      i2c.m_req  <= 1'b0;
      i2c.m_cmd  <= 4'h0;
      i2c.m_din  <= 8'h00;
    end else begin
      if (state == IDLE && (wr_req || rd_req)) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        is_wr   <= wr_req;
      end
      i2c.m_req <= issue;
      if (issue) begin
        i2c.m_cmd <= cmd_sel;
        i2c.m_din <= din_sel;
      end
      rdata_vld <= (state == R_DATA) && i2c.m_done;
      if (state == R_DATA && i2c.m_done) begin
        rdata <= i2c.m_dout;
      end
      wr_done <= is_wr && (state_next == FIN);
    end
  end

  assign ready     = (state == IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_eeprom_rw_ctrl.sv
// Randomized bench for eeprom_rw_ctrl: request-level reference model, bus-level EEPROM/master model.
module tb_eeprom_rw_ctrl;
  localparam int          WR_WAIT = 100;
  localparam logic [6:0]  DEV     = 7'b1010_000;
`ifdef EEPROM_WR_WAIT_EN
  localparam int WR_LAT   = WR_WAIT + 1;
  localparam int POKE_MIN = 30;
  localparam int POKE_MAX = 90;
`else
  localparam int WR_LAT   = 1;
  localparam int POKE_MIN = 1;
  localparam int POKE_MAX = 5;
`endif

  logic       clk, rst;
  logic       wr_req, rd_req;
  logic [7:0] addr, wdata;
  logic       ready;
  logic [7:0] rdata;
  logic       rdata_vld, wr_done;
  logic [9:0] state_dbg;

  eeprom_rw_ctrl_if bus();

  eeprom_rw_ctrl #(.DEV_ADDR(DEV), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rdata_vld(rdata_vld), .wr_done(wr_done),
    .i2c(bus), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];
  int          wr_pending = 0;
  logic [7:0]  mem_r[256];
  logic [7:0]  mem_s[256];
  int          last_event_cyc = 0;
  int          last_done_cyc = 0;
  logic [3:0]  last_done_cmd = 4'h0;
  int          slave_phase = 0;
  logic [7:0]  slave_ptr = 8'h00;
  logic [7:0]  rdata_hold = 8'h00;
  logic        fin_seen = 1'b0;
  logic [11:0] e;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      fin_seen = 1'b0;
    end else begin
      if (fin_seen) chk("ready_after_fin", ready, 1);
      fin_seen = 1'b0;
      if (bus.m_req) begin
        chk("m_req_gap", cyc - last_event_cyc, 2);
        chk("m_req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_cmd", bus.m_cmd, e[11:8]);
          chk("m_din", bus.m_din, e[7:0]);
        end
      end
      if (rdata_vld) begin
        chk("rd_expected", exp_rd_q.size() != 0, 1);
        if (exp_rd_q.size() != 0) chk("rdata", rdata, exp_rd_q.pop_front());
        chk("rd_lat", cyc - last_done_cyc, 1);
        chk("rd_last_cmd", last_done_cmd, 4'hC);
        chk("ready_in_fin", ready, 0);
        fin_seen = 1'b1;
      end
      if (wr_done) begin
        chk("wr_expected", wr_pending > 0, 1);
        if (wr_pending > 0) wr_pending--;
        chk("wr_lat", cyc - last_done_cyc, WR_LAT);
        chk("wr_last_cmd", last_done_cmd, 4'hA);
        chk("ready_in_fin", ready, 0);
        fin_seen = 1'b1;
      end
    end
  end

  // I2C master + EEPROM slave model
  initial begin : master_model
    logic [3:0] cmd;
    logic [7:0] din;
    int         lat;
    logic       aborted;
    bus.m_done = 1'b0;
    bus.m_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_req) begin
        cmd     = bus.m_cmd;
        din     = bus.m_din;
        lat     = $urandom_range(1, 4);
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          if (cmd[0]) begin
            if (din[7:1] != DEV) slave_phase = 0;
            else slave_phase = din[0] ? 3 : 1;
          end else if (cmd[1]) begin
            if (slave_phase == 1) begin
              slave_ptr   = din;
              slave_phase = 2;
            end else if (slave_phase == 2) begin
              mem_s[slave_ptr] = din;
              slave_ptr++;
            end
          end
          if (cmd[2]) begin
            bus.m_dout = (slave_phase == 3) ? mem_s[slave_ptr] : 8'hFF;
            slave_ptr++;
          end
          if (cmd[3]) slave_phase = 0;
          bus.m_done     = 1'b1;
          last_done_cyc  = cyc;
          last_event_cyc = cyc;
          last_done_cmd  = cmd;
          @(negedge clk);
          bus.m_done = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ready, 1);
  endtask

  task automatic push_req(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    wr_req = w;
    rd_req = r;
    addr   = a;
    wdata  = d;
    last_event_cyc = cyc;
    if (w) begin
      exp_q.push_back({4'h3, DEV, 1'b0});
      exp_q.push_back({4'h2, a});
      exp_q.push_back({4'hA, d});
      mem_r[a] = d;
      wr_pending++;
    end else if (r) begin
      exp_q.push_back({4'h3, DEV, 1'b0});
      exp_q.push_back({4'h2, a});
      exp_q.push_back({4'h3, DEV, 1'b1});
      exp_q.push_back({4'hC, 8'h00});
      exp_rd_q.push_back(mem_r[a]);
      rdata_hold = mem_r[a];
    end
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    addr   = 8'($urandom);
    wdata  = 8'($urandom);
    chk("ready_drop", ready, 0);
  endtask

  task automatic do_req(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                        input logic poke);
    wait_ready("ready_before_req");
    push_req(w, r, a, d);
    if (poke) begin
      repeat ($urandom_range(POKE_MIN, POKE_MAX)) @(negedge clk);
      if (!ready) begin
        rd_req = 1'b1;
        addr   = 8'($urandom);
        @(negedge clk);
        rd_req = 1'b0;
      end
    end
    wait_ready("ready_after_txn");
    @(negedge clk);
    chk("cmd_q_empty", exp_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    chk("wr_pending", wr_pending, 0);
    chk("rdata_hold", rdata, rdata_hold);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rdata_vld"}, rdata_vld, 0);
    chk({tag, "_wr_done"}, wr_done, 0);
    chk({tag, "_m_req"}, bus.m_req, 0);
    chk({tag, "_m_cmd"}, bus.m_cmd, 0);
    chk({tag, "_m_din"}, bus.m_din, 0);
  endtask

  initial begin : main
    int n;
    int kind;
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    addr   = 8'h00;
    wdata  = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem_r[i] = 8'($urandom);
      mem_s[i] = mem_r[i];
    end
    repeat (3) @(negedge clk);
    reset_values("rst_init");
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0);
    do_req(1'b0, 1'b1, 8'h3C, 8'h00, 1'b0);
    chk("rdata_3c", rdata, 8'hA5);
    do_req(1'b1, 1'b1, 8'h10, 8'($urandom), 1'b0);
    do_req(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b1);

    // abort a read during the repeated-start byte
    wait_ready("ready_before_abort");
    push_req(1'b0, 1'b1, 8'h3C, 8'h00);
    n = 0;
    while (!(bus.m_req && bus.m_cmd == 4'h3 && bus.m_din[0]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rrdev_reached", n < 200, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    reset_values("rst_mid");
    exp_q.delete();
    exp_rd_q.delete();
    rdata_hold  = 8'h00;
    slave_phase = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    do_req(1'b0, 1'b1, 8'h3C, 8'h00, 1'b0);
    chk("rdata_after_abort", rdata, 8'hA5);

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      do_req(kind != 1, kind != 0, 8'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eeprom_rw_ctrl.md
Name: eeprom_rw_ctrl

Overview:
- Transaction sequencer above the byte-level I2C master.
- Turns single-byte EEPROM write/read requests into the ordered master commands: device address, word address, data, with a repeated start for reads.
- Drives the master's `req`/`cmd`/`din` and consumes its `done`/`dout`. Sits between user logic (e.g. UART/key front-end) and the I2C master.

Parameters:
- DEV_ADDR, 7'b1010_000, 7-bit EEPROM device address.
- WR_WAIT, 250_000, clk cycles of post-write settle time (5 ms at 50 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_req  in  1  write request pulse; sampled only when ready=1
- rd_req  in  1  read request pulse; sampled only when ready=1
- addr  in  8  EEPROM word address, captured with the request
- wdata  in  8  write data, captured with wr_req
- ready  out  1  controller idle, request can be accepted
- rdata  out  8  read result, held until next read completes
- rdata_vld  out  1  one-cycle pulse, rdata updated
- wr_done  out  1  one-cycle pulse, write transaction finished
- m_req  out  1  to master `req`, one-cycle pulse
- m_cmd  out  4  to master `cmd`; bit0 START, bit1 WRITE, bit2 READ, bit3 STOP
- m_din  out  8  to master `din`
- m_dout  in  8  from master `dout`
- m_done  in  1  from master `done`, one-cycle pulse per finished byte

Behaviour:
- Reset values: ready=1, rdata=0, rdata_vld=0, wr_done=0, m_req=0, m_cmd=0, m_din=0, state=IDLE.
- Reset asserted mid-transaction aborts immediately to IDLE. The master is reset by the same source, so no bus recovery is done here.
- Request acceptance:
  - In IDLE with ready=1, wr_req or rd_req latches addr/wdata and kind.
  - If wr_req and rd_req are both high in the same cycle, the write wins and the read is dropped.
  - Requests while ready=0 are ignored, not queued.
  - ready drops in the cycle after acceptance.
- States, one-hot: IDLE, W_DEV, W_ADDR, W_DATA, R_DEV, R_ADDR, R_RDEV, R_DATA, W_WAIT, FIN.
- Byte issue rule:
  - On entry to each byte state, m_req pulses high for exactly one cycle (registered, cycle after the state change), with m_cmd/m_din valid in that cycle.
  - m_cmd/m_din hold their values until the next issue.
  - The state advances on m_done. The next m_req comes one cycle after the advance, when the master is already back in IDLE.
- Write sequence:
  - W_DEV: cmd=START|WRITE (4'b0011), din={DEV_ADDR,0}.
  - W_ADDR: cmd=WRITE (4'b0010), din=addr.
  - W_DATA: cmd=WRITE|STOP (4'b1010), din=wdata.
  - Then FIN (or W_WAIT, see the optional feature).
- Read sequence:
  - R_DEV: 4'b0011, {DEV_ADDR,0}.
  - R_ADDR: 4'b0010, addr.
  - R_RDEV: 4'b0011, {DEV_ADDR,1} (repeated start).
  - R_DATA: cmd=READ|STOP (4'b1100), din=don't-care(0). The master sends NACK then STOP.
  - On m_done in R_DATA: rdata<=m_dout, rdata_vld pulses the same cycle as the registered capture (cycle after m_done), then FIN.
- FIN: one cycle; wr_done pulses for writes (cycle after final m_done). Returns to IDLE; ready=1 the cycle after FIN.
- Slave NACK: the master ends the byte with STOP and still pulses m_done. The controller does not detect this and continues its sequence. A NACK is only visible as garbage rdata; this is accepted behaviour.
- m_done outside a byte state: ignored.

Optional Feature:
- Macro EEPROM_WR_WAIT_EN.
- Defined: after W_DATA m_done, enter W_WAIT.
  - A counter runs WR_WAIT cycles, then goes to FIN; ready stays 0 throughout.
  - wr_done pulses only after the wait.
  - Counter width is $clog2(WR_WAIT+1); it clears on reset and on entry.
- Undefined: W_DATA goes directly to FIN. W_WAIT and its counter are not synthesized; WR_WAIT is unused.

Test Plan:
- Reset, then wr_req with addr=8'h3C, wdata=8'hA5. Expect m_cmd/m_din sequence 4'h3/8'hA0, 4'h2/8'h3C, 4'hA/8'hA5. Expect one wr_done, then ready=1.
- rd_req with addr=8'h3C, slave model returns 8'hA5. Expect 4'h3/8'hA0, 4'h2/8'h3C, 4'h3/8'hA1, 4'hC/8'h00. Expect rdata=8'hA5 with a single rdata_vld pulse.
- wr_req and rd_req in the same cycle with addr=8'h10. Expect only the write sequence (3 m_req pulses) and no rdata_vld.
- rd_req pulsed while busy mid-write. Expect it ignored: exactly 3 m_req pulses, no read follows.
- Assert rst during R_RDEV. Expect all outputs at reset values the next cycle, and ready=1. A new rd_req then completes normally.
- With EEPROM_WR_WAIT_EN and WR_WAIT=100: a write gives wr_done exactly 100 cycles after the W_DATA m_done plus the FIN cycle. rd_req during the wait is ignored.
